// File: rtl/dbus_ctrl_if.sv
// Data-bus request/response types and the dbus port interface.
// Ports: dreq (controller -> bus request), dresp (bus -> controller response).
// master = controller side, slave = bus/memory side.

package dbus_pkg;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        logic [2:0]  size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;

endpackage

interface dbus_ctrl_if;
    dbus_pkg::dbus_req_t  dreq;
    dbus_pkg::dbus_resp_t dresp;

    modport master (output dreq, input dresp);
    modport slave  (input dreq, output dresp);
endinterface

// File: rtl/dbus_ctrl.sv
// Purpose: sequences memory-stage data-bus transactions; holds the request on the dbus until handshake.
// Latency: request on dbus 1 cycle after dreq_in.valid; rvalid pulses the cycle after data_ok (min 3 cycles/access).
// Backpressure: stall freezes the memory stage while a request is pending and through every DRAIN cycle.
//
// Ports: clk, reset (async active-high); dreq_in/flush from the memory stage;
// dbus (master modport: dreq out, dresp in); stall, rdata, rvalid, bus_err back to the pipeline.
// Parameters: TIMEOUT (>= 2) cycles from issue before abort; CNT_W with 2**CNT_W > TIMEOUT.

module dbus_ctrl
    import dbus_pkg::*;
#(
    parameter int TIMEOUT = 256,
    parameter int CNT_W   = 9
) (
    input  logic        clk,
    input  logic        reset,
    input  dbus_req_t   dreq_in,
    input  logic        flush,
    dbus_ctrl_if.master dbus,
    output logic        stall,
    output logic [63:0] rdata,
    output logic        rvalid,
    output logic        bus_err
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        DONE  = 3'd3,
        DRAIN = 3'd4
    } state_e;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e           state_q, state_d;
    dbus_req_t        dreq_q, dreq_d;
    logic [63:0]      rdata_q, rdata_d;
    logic             bus_err_q, bus_err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic addr_ok;
    logic data_ok;
    logic active_q;
    logic stay_active;

    assign addr_ok  = dbus.dresp.addr_ok;
    assign data_ok  = dbus.dresp.data_ok;
    assign active_q = (state_q == REQ) || (state_q == WAIT) || (state_q == DRAIN);

    always_comb begin
        state_d     = state_q;
        dreq_d      = dreq_q;
        rdata_d     = rdata_q;
        bus_err_d   = 1'b0;
        cnt_d       = cnt_q;
        stay_active = 1'b0;

        // Counts every cycle a transaction is outstanding; saturating.
        if (active_q && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        case (state_q)
            IDLE: begin
                dreq_d.valid = 1'b0;
                if (dreq_in.valid && !flush) begin
                    dreq_d       = dreq_in;
                    dreq_d.valid = 1'b1;
                    cnt_d        = '0;
                    state_d      = REQ;
                end
            end

            REQ: begin
                if (flush) begin
                    // Once the address is accepted the bus owes us a data phase,
                    // so it must be drained rather than dropped.
                    if (addr_ok && !data_ok) begin
                        state_d = DRAIN;
                    end else begin
                        dreq_d.valid = 1'b0;
                        state_d      = IDLE;
                    end
                end else if (addr_ok && data_ok) begin
                    rdata_d      = dbus.dresp.data;
                    dreq_d.valid = 1'b0;
                    state_d      = DONE;
                end else if (addr_ok) begin
                    state_d = WAIT;
                end
            end

            WAIT: begin
                if (data_ok) begin
                    dreq_d.valid = 1'b0;
                    if (flush) begin
                        state_d = IDLE;
                    end else begin
                        rdata_d = dbus.dresp.data;
                        state_d = DONE;
                    end
                end else if (flush) begin
                    state_d = DRAIN;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            DRAIN: begin
                if (data_ok) begin
                    dreq_d.valid = 1'b0;
                    state_d      = IDLE;
                end
            end

            default: begin
                dreq_d.valid = 1'b0;
                state_d      = IDLE;
            end
        endcase

        // A completing handshake or a flush-abort in the last allowed cycle wins;
        // only a transaction that would otherwise keep waiting is killed.
        stay_active = (state_d == REQ) || (state_d == WAIT) || (state_d == DRAIN);
        if (active_q && stay_active && (cnt_q == CNT_LAST)) begin
            dreq_d.valid = 1'b0;
            bus_err_d    = 1'b1;
            state_d      = IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            dreq_q    <= '0;
            rdata_q   <= '0;
            bus_err_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            dreq_q    <= dreq_d;
            rdata_q   <= rdata_d;
            bus_err_q <= bus_err_d;
            cnt_q     <= cnt_d;
        end
    end

    assign dbus.dreq = dreq_q;
    assign rdata     = rdata_q;
    assign rvalid    = (state_q == DONE);
    assign bus_err   = bus_err_q;

    // Held low during reset so the stage is released immediately even if it
    // still presents a valid request.
    assign stall = !reset &&
                   (((dreq_in.valid && !flush) && (state_q != DONE)) || (state_q == DRAIN));

endmodule

// File: tb/tb_dbus_ctrl.sv
// Directed bench for dbus_ctrl (TIMEOUT=8): zero-wait load, wait-state store,
// flush in REQ, flush in WAIT with drain, timeout, and asynchronous reset mid-transaction.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.

module tb_dbus_ctrl;
    import dbus_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        stall;
    logic [63:0] rdata;
    logic        rvalid;
    logic        bus_err;
    dbus_req_t   req_in;

    int n_cmp = 0;
    int n_err = 0;
    int rv    = 0;

    dbus_ctrl_if bus();

    dbus_ctrl #(
        .TIMEOUT(8),
        .CNT_W  (4)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .dreq_in(req_in),
        .flush  (flush),
        .dbus   (bus),
        .stall  (stall),
        .rdata  (rdata),
        .rvalid (rvalid),
        .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%h, expected 0x%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic set_req(input logic v, input logic [63:0] a, input logic [2:0] sz,
                           input logic [7:0] st, input logic [63:0] d);
        req_in.valid  = v;
        req_in.addr   = a;
        req_in.size   = sz;
        req_in.strobe = st;
        req_in.data   = d;
    endtask

    task automatic set_rsp(input logic aok, input logic dok, input logic [63:0] d);
        bus.dresp.addr_ok = aok;
        bus.dresp.data_ok = dok;
        bus.dresp.data    = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        set_req(1'b0, 64'h0, 3'd0, 8'h0, 64'h0);
        set_rsp(1'b0, 1'b0, 64'h0);
        #3;
        check("rst_dreq_vld", bus.dreq.valid, 0);
        check("rst_stall",    stall,          0);
        check("rst_rvalid",   rvalid,         0);
        check("rst_bus_err",  bus_err,        0);
        check("rst_rdata",    rdata,          0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // ---- zero-wait load ----
        tick(); set_req(1'b1, 64'h8000_1000, 3'd3, 8'hFF, 64'h0); settle();
        check("t1_c1_stall",    stall,          1);
        check("t1_c1_dreq_vld", bus.dreq.valid, 0);
        tick(); set_rsp(1'b1, 1'b1, 64'hDEADBEEF_CAFEF00D); settle();
        check("t1_c2_dreq_vld", bus.dreq.valid, 1);
        check("t1_c2_addr",     bus.dreq.addr,  64'h8000_1000);
        check("t1_c2_size",     bus.dreq.size,  3);
        check("t1_c2_stall",    stall,          1);
        check("t1_c2_rvalid",   rvalid,         0);
        tick(); set_rsp(1'b0, 1'b0, 64'h0); settle();
        check("t1_c3_stall",    stall,          0);
        check("t1_c3_rvalid",   rvalid,         1);
        check("t1_c3_rdata",    rdata,          64'hDEADBEEF_CAFEF00D);
        check("t1_c3_dreq_vld", bus.dreq.valid, 0);
        tick(); set_req(1'b0, 64'h0, 3'd0, 8'h0, 64'h0); settle();
        check("t1_c4_rvalid",   rvalid,         0);
        check("t1_c4_stall",    stall,          0);

        // ---- wait-state store: addr_ok on 2nd REQ cycle, data_ok 3 cycles later ----
        tick(); set_req(1'b1, 64'h8000_2000, 3'd3, 8'h0F, 64'h1234); settle();
        check("t2_idle_stall", stall, 1);
        rv = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            set_rsp(k == 1, k == 4, (k == 4) ? 64'h5555_AAAA_0000_1111 : 64'h0);
            settle();
            check($sformatf("t2_b%0d_vld", k),    bus.dreq.valid,  1);
            check($sformatf("t2_b%0d_addr", k),   bus.dreq.addr,   64'h8000_2000);
            check($sformatf("t2_b%0d_strobe", k), bus.dreq.strobe, 8'h0F);
            check($sformatf("t2_b%0d_data", k),   bus.dreq.data,   64'h1234);
            check($sformatf("t2_b%0d_stall", k),  stall,           1);
            if (rvalid) rv++;
        end
        tick(); set_rsp(1'b0, 1'b0, 64'h0); settle();
        check("t2_done_stall",  stall,  0);
        check("t2_done_rvalid", rvalid, 1);
        check("t2_done_rdata",  rdata,  64'h5555_AAAA_0000_1111);
        if (rvalid) rv++;
        tick(); set_req(1'b0, 64'h0, 3'd0, 8'h0, 64'h0); settle();
        check("t2_after_vld", bus.dreq.valid, 0);
        if (rvalid) rv++;
        check("t2_rvalid_pulses", rv, 1);

        // ---- flush in REQ before addr_ok, then a new request ----
        tick(); set_req(1'b1, 64'h8000_3000, 3'd2, 8'h0F, 64'h0); settle();
        check("t3_idle_stall", stall, 1);
        tick(); flush = 1'b1; settle();
        check("t3_flush_stall", stall,          0);
        check("t3_flush_vld",   bus.dreq.valid, 1);
        tick(); flush = 1'b0; set_req(1'b0, 64'h0, 3'd0, 8'h0, 64'h0); settle();
        check("t3_post_vld",    bus.dreq.valid, 0);
        check("t3_post_rvalid", rvalid,         0);
        check("t3_post_stall",  stall,          0);
        tick(); set_req(1'b1, 64'h8000_3008, 3'd3, 8'hFF, 64'h0); settle();
        check("t3_new_stall", stall,          1);
        check("t3_new_vld0",  bus.dreq.valid, 0);
        tick(); set_rsp(1'b1, 1'b1, 64'h77); settle();
        check("t3_new_vld",  bus.dreq.valid, 1);
        check("t3_new_addr", bus.dreq.addr,  64'h8000_3008);
        tick(); set_rsp(1'b0, 1'b0, 64'h0); settle();
        check("t3_new_rvalid", rvalid, 1);
        check("t3_new_rdata",  rdata,  64'h77);
        tick(); set_req(1'b0, 64'h0, 3'd0, 8'h0, 64'h0); settle();

        // ---- flush in WAIT, data_ok 4 cycles later ----
        tick(); set_req(1'b1, 64'h8000_4000, 3'd3, 8'hFF, 64'h0); settle();
        tick(); set_rsp(1'b1, 1'b0, 64'h0); settle();
        check("t4_req_vld", bus.dreq.valid, 1);
        tick(); set_rsp(1'b0, 1'b0, 64'h0); flush = 1'b1; settle();
        check("t4_flush_stall", stall, 0);
        rv = 0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (k == 1) begin
                flush = 1'b0;
                set_req(1'b0, 64'h0, 3'd0, 8'h0, 64'h0);
            end
            set_rsp(1'b0, k == 4, 64'hBAD0_BAD0_BAD0_BAD0);
            settle();
            check($sformatf("t4_drain%0d_stall", k), stall,          1);
            check($sformatf("t4_drain%0d_vld", k),   bus.dreq.valid, 1);
            if (rvalid) rv++;
        end
        tick(); set_rsp(1'b0, 1'b0, 64'h0); set_req(1'b1, 64'h8000_5000, 3'd3, 8'hFF, 64'h0); settle();
        check("t4_idle_vld",   bus.dreq.valid, 0);
        check("t4_idle_stall", stall,          1);
        if (rvalid) rv++;
        check("t4_no_rvalid", rv, 0);
        tick(); set_rsp(1'b1, 1'b1, 64'h99); settle();
        check("t4_new_vld",  bus.dreq.valid, 1);
        check("t4_new_addr", bus.dreq.addr,  64'h8000_5000);
        tick(); set_rsp(1'b0, 1'b0, 64'h0); settle();
        check("t4_new_rvalid", rvalid, 1);
        check("t4_new_rdata",  rdata,  64'h99);
        tick(); set_req(1'b0, 64'h0, 3'd0, 8'h0, 64'h0); settle();

        // ---- timeout: bus silent, bus_err 8 cycles after issue ----
        tick(); set_req(1'b1, 64'h8000_6000, 3'd3, 8'hFF, 64'h0); settle();
        for (int k = 0; k < 8; k++) begin
            tick(); settle();
            check($sformatf("t5_c%0d_vld", k),     bus.dreq.valid, 1);
            check($sformatf("t5_c%0d_bus_err", k), bus_err,        0);
        end
        tick(); set_req(1'b1, 64'h8000_7000, 3'd3, 8'hFF, 64'h0); settle();
        check("t5_err_pulse", bus_err,        1);
        check("t5_err_vld",   bus.dreq.valid, 0);
        check("t5_err_stall", stall,          1);
        check("t5_err_rvalid", rvalid,        0);
        tick(); set_rsp(1'b1, 1'b1, 64'hAB); settle();
        check("t5_next_bus_err", bus_err,        0);
        check("t5_next_vld",     bus.dreq.valid, 1);
        check("t5_next_addr",    bus.dreq.addr,  64'h8000_7000);
        tick(); set_rsp(1'b0, 1'b0, 64'h0); settle();
        check("t5_next_rvalid", rvalid, 1);
        check("t5_next_rdata",  rdata,  64'hAB);
        tick(); set_req(1'b0, 64'h0, 3'd0, 8'h0, 64'h0); settle();

        // ---- asynchronous reset while in WAIT ----
        tick(); set_req(1'b1, 64'h8000_8000, 3'd3, 8'hFF, 64'h0); settle();
        tick(); set_rsp(1'b1, 1'b0, 64'h0); settle();
        tick(); set_rsp(1'b0, 1'b0, 64'h0);
        #1;
        check("t6_wait_vld",   bus.dreq.valid, 1);
        check("t6_wait_stall", stall,          1);
        reset = 1'b1;
        #1;
        check("t6_rst_vld",    bus.dreq.valid, 0);
        check("t6_rst_stall",  stall,          0);
        check("t6_rst_rvalid", rvalid,         0);
        check("t6_rst_rdata",  rdata,          0);
        tick(); tick();
        set_req(1'b0, 64'h0, 3'd0, 8'h0, 64'h0);
        reset = 1'b0;
        settle();
        check("t6_rel_vld",   bus.dreq.valid, 0);
        check("t6_rel_stall", stall,          0);
        tick(); set_req(1'b1, 64'h8000_9000, 3'd3, 8'hFF, 64'h0); settle();
        check("t6_new_stall", stall, 1);
        tick(); set_rsp(1'b1, 1'b1, 64'h42); settle();
        check("t6_new_vld",  bus.dreq.valid, 1);
        check("t6_new_addr", bus.dreq.addr,  64'h8000_9000);
        tick(); set_rsp(1'b0, 1'b0, 64'h0); settle();
        check("t6_new_rvalid", rvalid, 1);
        check("t6_new_rdata",  rdata,  64'h42);
        tick(); set_req(1'b0, 64'h0, 3'd0, 8'h0, 64'h0); settle();
        check("t6_end_rvalid", rvalid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dbus_ctrl.md
Name: dbus_ctrl

Overview:
- Sequences data-bus transactions issued by the memory stage: captures the request, holds it stable on the dbus until the handshake completes, and stalls the pipeline meanwhile.
- Returns load data with a one-cycle valid pulse.
- Handles flush/exception mid-flight, including draining committed transactions.
- Aborts hung transactions with a bus-error pulse.
- Sits between the memory stage and the dbus port of the core.

Parameters:
- TIMEOUT, 256: max cycles from issue to data_ok before abort; must be ≥ 2.
- CNT_W, 9: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- dreq_in  in  dbus_req_t  request from the memory stage (valid, addr[63:0], size[2:0], strobe[7:0], data[63:0]); held stable by the stage while stall=1.
- flush  in  1  kill the current request (exception/redirect).
- dreq  out  dbus_req_t  request driven to the dbus.
- dresp  in  dbus_resp_t  addr_ok, data_ok, data[63:0].
- stall  out  1  freeze the memory stage and everything upstream.
- rdata  out  64  captured dresp.data.
- rvalid  out  1  one-cycle pulse; rdata is valid.
- bus_err  out  1  one-cycle pulse on timeout.

Behaviour:
- Reset values: state=IDLE, dreq='0, rdata=0, rvalid=0, bus_err=0, counter=0.
- stall is combinational: 1 when dreq_in.valid=1 and flush=0 and state≠DONE; also 1 in every DRAIN cycle.
- States and transitions:
  - IDLE: if dreq_in.valid and !flush, register dreq_in into dreq with dreq.valid=1, clear counter, go to REQ. Otherwise dreq.valid=0. Latency is 1 cycle: dreq.valid rises the cycle after dreq_in.valid.
  - REQ: dreq held unchanged.
    - addr_ok & data_ok same cycle: latch rdata, go to DONE.
    - addr_ok only: go to WAIT.
    - flush (no addr_ok): drop dreq.valid, go to IDLE; the transaction is not issued.
    - flush with addr_ok=1, no data_ok: go to DRAIN.
    - flush with addr_ok=1 and data_ok=1: go to IDLE; data discarded, no rvalid.
  - WAIT: dreq.valid stays 1 (the bus holds the request until data_ok).
    - data_ok: latch dresp.data into rdata, drop dreq.valid, go to DONE.
    - flush without data_ok: go to DRAIN.
    - flush with data_ok: go to IDLE; no rvalid.
  - DONE (exactly 1 cycle): rvalid=1, stall=0, so the pipeline advances this cycle. Next state is IDLE.
    - If flush=1 in DONE, rvalid is still 1; the pipeline discards it.
  - DRAIN: dreq.valid stays 1, stall=1, rvalid never asserted. On data_ok go to IDLE, with dreq.valid=0 the next cycle.
- Timeout:
  - The counter increments every cycle in REQ/WAIT/DRAIN and saturates.
  - When counter reaches TIMEOUT-1 without the completing handshake: bus_err=1 for 1 cycle, dreq.valid=0, go to IDLE.
  - Timeout in DRAIN also pulses bus_err.
- Stores: same flow; rdata is latched but meaningless; rvalid still pulses in DONE.
- A new request is accepted only in IDLE. Back-to-back requests cost ≥ 1 IDLE cycle each: minimum 3 cycles per access (IDLE, REQ, DONE) with a zero-wait bus.
- Reset asserted mid-transaction: everything returns to reset values immediately (asynchronously); the outstanding bus transaction is abandoned.

Test Plan:
- Zero-wait load: dreq_in.valid=1 with addr=0x80001000, size=3. Bus asserts addr_ok=data_ok=1 in the first REQ cycle, data=0xDEADBEEF_CAFEF00D → dreq.valid high for 1 cycle; stall=1,1,0; rvalid=1 with that data in the third cycle.
- Wait-state store: strobe=0x0F, data=0x1234. addr_ok after 2 cycles, data_ok 3 cycles later → dreq fields constant throughout; stall deasserts in DONE; exactly one rvalid pulse.
- Flush in REQ before addr_ok → dreq.valid low the next cycle; stall low while flush=1; no rvalid; state IDLE.
- Flush in WAIT, data_ok 4 cycles later → stall stays 1 through DRAIN; rvalid never pulses; a new request is accepted after data_ok.
- TIMEOUT=8, bus never answers → bus_err pulses in cycle 8 after issue; dreq.valid=0; the next request is accepted.
- Reset asserted in WAIT → dreq.valid, stall, rvalid all 0 without waiting for a clock edge; IDLE after reset release.
